memory_access: RTL and testbench
================================

Name: memory_access

Overview:
- MEM stage of the 5-stage MIPS pipeline. Sits between the EX/MEM register and the write-back stage.
- Performs byte, halfword and word loads and stores on an internal data RAM.
- Registers the load result, the ALU result, mem_to_reg and the destination-register controls into the MEM/WB boundary.
- data_out feeds write-back data_in, dir_out feeds dir, and mem_to_reg_out feeds mem_to_reg.

Parameters:
- DATA_W, 32, datapath width. Only 32 is supported.
- ADDR_W, 10, word-address width of the data RAM (2^ADDR_W words).
- REG_W, 5, destination register index width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- alu_result  in  32  ALU result; also the byte address for loads and stores
- store_data  in  32  rt value to store
- mem_read  in  1  load request
- mem_write  in  1  store request
- mem_size  in  2  access size: 00 byte, 01 half, 10 word, 11 treated as word
- mem_unsigned  in  1  zero-extend loads (lbu/lhu) when 1, sign-extend when 0
- mem_to_reg_in  in  1  write-back mux select from EX/MEM
- reg_write_in  in  1  register-file write enable from EX/MEM
- rd_in  in  REG_W  destination register
- stall  in  1  hold the MEM/WB outputs
- flush  in  1  insert a bubble
- data_out  out  32  registered, extended load data
- dir_out  out  32  registered alu_result
- mem_to_reg_out  out  1  registered mem_to_reg_in
- reg_write_out  out  1  registered write enable
- rd_out  out  REG_W  registered rd_in
- misaligned  out  1  registered alignment-fault flag

Behaviour:
- **Reset.** rst high clears every output to 0 immediately. RAM contents are not affected by rst; they are zero-initialised at time 0 for simulation only.
- **Latency.** Inputs sampled at posedge N appear on the outputs after posedge N (1 cycle).
- **RAM organisation.**
  - RAM is 2^ADDR_W x 32 with an asynchronous read and a synchronous write at posedge.
  - Word index is alu_result[ADDR_W+1:2]. Upper address bits are ignored, so addresses alias (wrap-around).
- **Lane selection.** Little-endian.
  - Byte lane k = alu_result[1:0], occupying bits 8k+7:8k.
  - Halfword lane = alu_result[1], occupying bits 16h+15:16h.
- **Alignment fault.** A fault occurs when (mem_read or mem_write) and either:
  - the access is a half with alu_result[0]=1, or
  - the access is a word with alu_result[1:0]!=00.
- **On a fault:**
  - no RAM write;
  - data_out <= 0 and reg_write_out <= 0;
  - misaligned <= 1 for that cycle only;
  - dir_out, rd_out and mem_to_reg_out still register normally.
- **Store.** Only the addressed lane(s) are written: low byte, low half or the full word of store_data. Other lanes are unchanged.
- **Load.**
  - The selected lane is sign-extended or zero-extended per mem_unsigned; words are passed through.
  - When mem_read=0, data_out <= 0.
- **Read-during-write, same word.** A load returns the pre-write contents; the new data is visible from cycle N+1.
- **mem_read and mem_write both 1.** The store is performed and the load returns the old contents.
- **Stall.** All output registers hold their values and the RAM write is suppressed.
- **Flush.**
  - Flush has priority over stall.
  - Outputs are loaded with a bubble: all zero, including reg_write_out=0, mem_to_reg_out=0 and misaligned=0.
  - The RAM write is suppressed.
- **Reset mid-operation.** A store sampled on the same edge as rst asserting is not performed.

Optional Feature:
- Macro: MEMORY_ACCESS_STATS_EN.
- Defined:
  - Adds output ports load_count[31:0] and store_count[31:0].
  - A counter increments on each edge where a non-faulting, non-stalled, non-flushed load or store (respectively) is accepted.
  - Counters saturate at 32'hFFFFFFFF and reset to 0 on rst.
  - A combined read+write access increments both counters.
- Not defined: neither port nor the counter logic exists, and behaviour is otherwise identical.

Test Plan:
- **Word store then load.**
  - Stimulus: sw 32'hDEADBEEF @ addr 0x10, then lw @ 0x10 with mem_to_reg_in=1, rd_in=5.
  - Required: data_out=0xDEADBEEF, mem_to_reg_out=1, reg_write_out=1, rd_out=5 one cycle later.
- **Byte and half extension.**
  - Stimulus: word 0x80FF7F01 @ 0x20; lb @0x23, lbu @0x23, lh @0x22, lhu @0x22, lb @0x20.
  - Required, in order: 0xFFFFFF80, 0x00000080, 0xFFFF80FF, 0x000080FF, 0x00000001.
- **Partial stores.**
  - Stimulus: word 0 @ 0x30; sb 0xAA @0x31; sh 0x1234 @0x32; then lw @0x30.
  - Required: 0x1234AA00.
- **Misalignment.**
  - Stimulus: sw 0x55555555 @0x41; then lw @0x40; also lh @0x43.
  - Required: misaligned=1 and reg_write_out=0 on the faulting cycles; the lw returns the prior contents, unchanged.
- **Stall and flush.**
  - Stimulus: stall during sw @0x50, followed by flush together with stall.
  - Required: RAM unchanged, outputs held during stall, then all outputs 0 after the flush edge.
- **Async reset.**
  - Stimulus: rst mid-cycle after lw @0x10 produced 0xDEADBEEF.
  - Required: all outputs 0 immediately without waiting for a clock edge, and the RAM still holds 0xDEADBEEF; with MEMORY_ACCESS_STATS_EN defined, both counters read 0.

Source files
------------

// File: rtl/memory_access.sv
// memory_access -- MEM stage of the 5-stage MIPS pipeline.
// Byte/halfword/word loads and stores on an internal 2^ADDR_W x 32 data RAM
// (asynchronous read, synchronous write), little-endian lanes, alignment
// fault detection, and a registered MEM/WB boundary with stall and flush.
// Optional feature macro: MEMORY_ACCESS_STATS_EN adds saturating
// load_count / store_count outputs.
module memory_access #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] store_data,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        mem_size,
    input  logic              mem_unsigned,
    input  logic              mem_to_reg_in,
    input  logic              reg_write_in,
    input  logic [REG_W-1:0]  rd_in,
    input  logic              stall,
    input  logic              flush,
    output logic [DATA_W-1:0] data_out,
    output logic [DATA_W-1:0] dir_out,
    output logic              mem_to_reg_out,
    output logic              reg_write_out,
    output logic [REG_W-1:0]  rd_out,
    output logic              misaligned
`ifdef MEMORY_ACCESS_STATS_EN
    ,
    output logic [31:0]       load_count,
    output logic [31:0]       store_count
`endif
);

    localparam int DEPTH = 1 << ADDR_W;

    // Data RAM; contents survive rst
    logic [DATA_W-1:0] mem_q [0:DEPTH-1];

    logic [ADDR_W-1:0] word_idx_s;
    logic [1:0]        lane_s;
    logic [DATA_W-1:0] rd_word_s;
    logic [7:0]        byte_s;
    logic [15:0]       half_s;
    logic [DATA_W-1:0] load_val_s;
    logic [DATA_W-1:0] wdata_s;
    logic              fault_s;
    logic              accept_s;
    logic              we_s;

    // Upper address bits alias by design; fold them into a sink net
    logic              unused_s;
    assign unused_s = ^alu_result[DATA_W-1:ADDR_W+2];

    assign word_idx_s = alu_result[ADDR_W+1:2];
    assign lane_s     = alu_result[1:0];
    assign rd_word_s  = mem_q[word_idx_s];
    assign byte_s     = rd_word_s[{lane_s, 3'b000} +: 8];
    assign half_s     = rd_word_s[{lane_s[1], 4'b0000} +: 16];

    // Half must be 2-byte aligned, word (and size 11) must be 4-byte aligned
    assign fault_s = (mem_read | mem_write) &
                     (((mem_size == 2'b01) & lane_s[0]) |
                      (mem_size[1] & (lane_s != 2'b00)));

    // An access is accepted when it is neither stalled, flushed nor faulting
    assign accept_s = ~fault_s & ~stall & ~flush;
    assign we_s     = mem_write & accept_s & ~rst;

    // Extract the addressed lane and extend it to the datapath width
    always_comb begin
        load_val_s = {DATA_W{1'b0}};
        case (mem_size)
            2'b00: begin
                if (mem_unsigned) begin
                    load_val_s = {24'h000000, byte_s};
                end else begin
                    load_val_s = {{24{byte_s[7]}}, byte_s};
                end
            end
            2'b01: begin
                if (mem_unsigned) begin
                    load_val_s = {16'h0000, half_s};
                end else begin
                    load_val_s = {{16{half_s[15]}}, half_s};
                end
            end
            default: load_val_s = rd_word_s;
        endcase
    end

    // Merge the store data into the addressed lane(s) of the current word
    always_comb begin
        wdata_s = rd_word_s;
        case (mem_size)
            2'b00:   wdata_s[{lane_s, 3'b000} +: 8]     = store_data[7:0];
            2'b01:   wdata_s[{lane_s[1], 4'b0000} +: 16] = store_data[15:0];
            default: wdata_s = store_data;
        endcase
    end

    // Synchronous RAM write; the read above sees pre-write contents
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem_q[word_idx_s] <= wdata_s;
        end
    end

    logic [DATA_W-1:0] data_q, data_d;
    logic [DATA_W-1:0] dir_q, dir_d;
    logic              m2r_q, m2r_d;
    logic              regw_q, regw_d;
    logic [REG_W-1:0]  rd_q, rd_d;
    logic              mis_q, mis_d;

    // MEM/WB next state: flush beats stall, stall holds, otherwise capture
    always_comb begin
        data_d = data_q;
        dir_d  = dir_q;
        m2r_d  = m2r_q;
        regw_d = regw_q;
        rd_d   = rd_q;
        mis_d  = mis_q;
        if (flush) begin
            data_d = {DATA_W{1'b0}};
            dir_d  = {DATA_W{1'b0}};
            m2r_d  = 1'b0;
            regw_d = 1'b0;
            rd_d   = {REG_W{1'b0}};
            mis_d  = 1'b0;
        end else if (stall) begin
            data_d = data_q;
            mis_d  = mis_q;
        end else begin
            if (mem_read && !fault_s) begin
                data_d = load_val_s;
            end else begin
                data_d = {DATA_W{1'b0}};
            end
            dir_d  = alu_result;
            m2r_d  = mem_to_reg_in;
            regw_d = reg_write_in & ~fault_s;
            rd_d   = rd_in;
            mis_d  = fault_s;
        end
    end

    // MEM/WB boundary registers with asynchronous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= {DATA_W{1'b0}};
            dir_q  <= {DATA_W{1'b0}};
            m2r_q  <= 1'b0;
            regw_q <= 1'b0;
            rd_q   <= {REG_W{1'b0}};
            mis_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            dir_q  <= dir_d;
            m2r_q  <= m2r_d;
            regw_q <= regw_d;
            rd_q   <= rd_d;
            mis_q  <= mis_d;
        end
    end

    assign data_out       = data_q;
    assign dir_out        = dir_q;
    assign mem_to_reg_out = m2r_q;
    assign reg_write_out  = regw_q;
    assign rd_out         = rd_q;
    assign misaligned     = mis_q;

`ifdef MEMORY_ACCESS_STATS_EN
    logic [31:0] load_cnt_q;
    logic [31:0] store_cnt_q;

    // Saturating counters of accepted loads and stores
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_cnt_q  <= 32'h0000_0000;
            store_cnt_q <= 32'h0000_0000;
        end else begin
            if (mem_read && accept_s && (load_cnt_q != 32'hFFFF_FFFF)) begin
                load_cnt_q <= load_cnt_q + 32'd1;
            end
            if (mem_write && accept_s && (store_cnt_q != 32'hFFFF_FFFF)) begin
                store_cnt_q <= store_cnt_q + 32'd1;
            end
        end
    end

    assign load_count  = load_cnt_q;
    assign store_count = store_cnt_q;
`endif

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: a byte-addressed behavioural model,
// a per-cycle compare process, and literal expectations at key points.
module tb_memory_access;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] alu_result, store_data;
    logic        mem_read, mem_write, mem_unsigned, mem_to_reg_in, reg_write_in;
    logic [1:0]  mem_size;
    logic [4:0]  rd_in;
    logic        stall, flush;
    logic [31:0] data_out, dir_out;
    logic        mem_to_reg_out, reg_write_out, misaligned;
    logic [4:0]  rd_out;
`ifdef MEMORY_ACCESS_STATS_EN
    logic [31:0] load_count, store_count;
`endif

    memory_access dut (
        .clk(clk), .rst(rst), .alu_result(alu_result), .store_data(store_data),
        .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
        .mem_unsigned(mem_unsigned), .mem_to_reg_in(mem_to_reg_in),
        .reg_write_in(reg_write_in), .rd_in(rd_in), .stall(stall), .flush(flush),
        .data_out(data_out), .dir_out(dir_out), .mem_to_reg_out(mem_to_reg_out),
        .reg_write_out(reg_write_out), .rd_out(rd_out), .misaligned(misaligned)
`ifdef MEMORY_ACCESS_STATS_EN
        , .load_count(load_count), .store_count(store_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: flat byte memory (4096 bytes, address wraps)
    logic [7:0]  mb [0:4095];
    logic [31:0] e_data, e_dir;
    logic        e_m2r, e_regw, e_mis;
    logic [4:0]  e_rd;
    logic [31:0] e_lc, e_sc;

    always @(posedge clk or posedge rst) begin
        int nb;
        int ba;
        logic flt;
        logic [31:0] v;
        logic [31:0] mask;
        if (rst) begin
            e_data = 0; e_dir = 0; e_m2r = 0; e_regw = 0; e_rd = 0; e_mis = 0;
            e_lc = 0; e_sc = 0;
        end else begin
            nb  = (mem_size == 2'd0) ? 1 : (mem_size == 2'd1) ? 2 : 4;
            ba  = int'(alu_result % 32'd4096);
            flt = (mem_read || mem_write) && ((alu_result % 32'(nb)) != 0);
            if (flush) begin
                e_data = 0; e_dir = 0; e_m2r = 0; e_regw = 0; e_rd = 0; e_mis = 0;
            end else if (!stall) begin
                v = 0;
                if (mem_read && !flt) begin
                    for (int i = 0; i < nb; i++) v = v | (32'(mb[ba + i]) << (8 * i));
                    if (nb < 4 && !mem_unsigned && v[8 * nb - 1]) begin
                        mask = (32'd1 << (8 * nb)) - 32'd1;
                        v = v | ~mask;
                    end
                    if (e_lc != 32'hFFFFFFFF) e_lc = e_lc + 1;
                end
                e_data = v;
                e_dir  = alu_result;
                e_m2r  = mem_to_reg_in;
                e_regw = reg_write_in && !flt;
                e_rd   = rd_in;
                e_mis  = flt;
                if (mem_write && !flt) begin
                    for (int i = 0; i < nb; i++) mb[ba + i] = store_data[8 * i +: 8];
                    if (e_sc != 32'hFFFFFFFF) e_sc = e_sc + 1;
                end
            end
        end
    end

    // Per-cycle compare of every output against the model
    always @(negedge clk) begin
        chk("data_out", data_out, e_data);
        chk("dir_out", dir_out, e_dir);
        chk("mem_to_reg_out", {31'd0, mem_to_reg_out}, {31'd0, e_m2r});
        chk("reg_write_out", {31'd0, reg_write_out}, {31'd0, e_regw});
        chk("rd_out", {27'd0, rd_out}, {27'd0, e_rd});
        chk("misaligned", {31'd0, misaligned}, {31'd0, e_mis});
`ifdef MEMORY_ACCESS_STATS_EN
        chk("load_count", load_count, e_lc);
        chk("store_count", store_count, e_sc);
`endif
    end

    // One pipeline cycle: drive inputs, let the edge pass, settle
    task automatic step(input logic rd, input logic wr, input logic [1:0] sz,
                        input logic uns, input logic [31:0] addr, input logic [31:0] sd,
                        input logic m2r, input logic rw, input logic [4:0] rdi,
                        input logic st, input logic fl);
        mem_read = rd; mem_write = wr; mem_size = sz; mem_unsigned = uns;
        alu_result = addr; store_data = sd; mem_to_reg_in = m2r;
        reg_write_in = rw; rd_in = rdi; stall = st; flush = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic sw(input logic [31:0] a, input logic [31:0] d);
        step(1'b0, 1'b1, 2'b10, 1'b0, a, d, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic ld(input logic [1:0] sz, input logic uns, input logic [31:0] a, input logic [4:0] r);
        step(1'b1, 1'b0, sz, uns, a, 32'd0, 1'b1, 1'b1, r, 1'b0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) mb[i] = 8'h00;
        rst = 1'b1;
        step(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_0000, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        chk("reset data_out", data_out, 32'h0);
        chk("reset reg_write_out", {31'd0, reg_write_out}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;

        // Word store then load
        sw(32'h10, 32'hDEADBEEF);
        ld(2'b10, 1'b0, 32'h10, 5'd5);
        chk("lw data", data_out, 32'hDEADBEEF);
        chk("lw m2r", {31'd0, mem_to_reg_out}, 32'd1);
        chk("lw regw", {31'd0, reg_write_out}, 32'd1);
        chk("lw rd", {27'd0, rd_out}, 32'd5);

        // Byte and half extension
        sw(32'h20, 32'h80FF7F01);
        ld(2'b00, 1'b0, 32'h23, 5'd1); chk("lb 23", data_out, 32'hFFFFFF80);
        ld(2'b00, 1'b1, 32'h23, 5'd1); chk("lbu 23", data_out, 32'h00000080);
        ld(2'b01, 1'b0, 32'h22, 5'd1); chk("lh 22", data_out, 32'hFFFF80FF);
        ld(2'b01, 1'b1, 32'h22, 5'd1); chk("lhu 22", data_out, 32'h000080FF);
        ld(2'b00, 1'b0, 32'h20, 5'd1); chk("lb 20", data_out, 32'h00000001);
        ld(2'b01, 1'b0, 32'h20, 5'd1); chk("lh 20", data_out, 32'h00007F01);

        // Partial stores
        sw(32'h30, 32'h0);
        step(1'b0, 1'b1, 2'b00, 1'b0, 32'h31, 32'h555555AA, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 2'b01, 1'b0, 32'h32, 32'h66661234, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        ld(2'b10, 1'b0, 32'h30, 5'd2); chk("partial", data_out, 32'h1234AA00);

        // Misalignment
        sw(32'h40, 32'hCAFEF00D);
        step(1'b0, 1'b1, 2'b10, 1'b0, 32'h41, 32'h55555555, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0);
        chk("sw41 mis", {31'd0, misaligned}, 32'd1);
        chk("sw41 regw", {31'd0, reg_write_out}, 32'd0);
        ld(2'b01, 1'b0, 32'h43, 5'd4);
        chk("lh43 mis", {31'd0, misaligned}, 32'd1);
        chk("lh43 regw", {31'd0, reg_write_out}, 32'd0);
        chk("lh43 data", data_out, 32'd0);
        chk("lh43 dir", dir_out, 32'h43);
        ld(2'b10, 1'b0, 32'h40, 5'd4);
        chk("lw40 data", data_out, 32'hCAFEF00D);
        chk("lw40 mis", {31'd0, misaligned}, 32'd0);
        ld(2'b11, 1'b0, 32'h42, 5'd4);
        chk("size11 mis", {31'd0, misaligned}, 32'd1);

        // Stall and flush
        sw(32'h50, 32'h11223344);
        ld(2'b10, 1'b0, 32'h50, 5'd7);
        step(1'b0, 1'b1, 2'b10, 1'b0, 32'h50, 32'h99999999, 1'b0, 1'b0, 5'd9, 1'b1, 1'b0);
        chk("stall hold data", data_out, 32'h11223344);
        chk("stall hold rd", {27'd0, rd_out}, 32'd7);
        step(1'b0, 1'b1, 2'b10, 1'b0, 32'h50, 32'h99999999, 1'b1, 1'b1, 5'd9, 1'b1, 1'b1);
        chk("flush data", data_out, 32'd0);
        chk("flush dir", dir_out, 32'd0);
        chk("flush regw", {31'd0, reg_write_out}, 32'd0);
        ld(2'b10, 1'b0, 32'h50, 5'd7); chk("ram after stall", data_out, 32'h11223344);

        // Wrap-around aliasing and read+write together
        sw(32'h60, 32'h0BADF00D);
        ld(2'b10, 1'b0, 32'h1060, 5'd8); chk("alias", data_out, 32'h0BADF00D);
        sw(32'h70, 32'h1);
        step(1'b1, 1'b1, 2'b10, 1'b0, 32'h70, 32'h2, 1'b1, 1'b1, 5'd8, 1'b0, 1'b0);
        chk("rw old", data_out, 32'h1);
        ld(2'b10, 1'b0, 32'h70, 5'd8); chk("rw new", data_out, 32'h2);

        // Async reset mid-cycle
        ld(2'b10, 1'b0, 32'h10, 5'd5); chk("pre-rst", data_out, 32'hDEADBEEF);
        #2 rst = 1'b1;
        #1;
        chk("async data", data_out, 32'd0);
        chk("async dir", dir_out, 32'd0);
        chk("async rd", {27'd0, rd_out}, 32'd0);
        chk("async m2r", {31'd0, mem_to_reg_out}, 32'd0);
`ifdef MEMORY_ACCESS_STATS_EN
        chk("async lc", load_count, 32'd0);
        chk("async sc", store_count, 32'd0);
`endif
        step(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h77777777, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        ld(2'b10, 1'b0, 32'h10, 5'd5); chk("ram kept", data_out, 32'hDEADBEEF);
        step(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
